video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_pkg.sv | 26 ++
 rtl/video_wrap_cnt.sv | 38 +++
 rtl/video_timing_gen.sv | 143 ++++++++++++++
 tb/tb_video_timing_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared timing constants and FSM encoding for the video timing generator
// and the downstream filter controller.
package video_timing_pkg;

  localparam int DEF_HBP = 3;
  localparam int DEF_HAC = 1920;
  localparam int DEF_HFP = 3;
  localparam int DEF_VBP = 3;
  localparam int DEF_VAC = 1080;
  localparam int DEF_VFP = 3;

  localparam int CNT_W   = 12;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_STOP = 3'b100
  } vt_state_e;

  // One sync cycle/line plus back porch, active region and front porch.
  function automatic int vt_period(input int bp, input int ac, input int fp);
    return 1 + bp + ac + fp;
  endfunction

endpackage

// File: rtl/video_wrap_cnt.sv
// Wrapping counter with clear, enable and terminal-count flag; exposes the
// next value so the parent can register outputs aligned with the count.
module video_wrap_cnt #(
  parameter int           W    = 12,
  parameter logic [W-1:0] LAST = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_nxt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_nxt;

  assign o_tc  = (r_cnt == LAST);
  assign o_nxt = w_nxt;

  always_comb begin
    w_nxt = r_cnt;
    if (i_clr) begin
      w_nxt = '0;
    end else if (i_en) begin
      w_nxt = o_tc ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_nxt;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: one-cycle hs/vs pulses, data-enable with pixel
// coordinates, frame-done pulse and a run/stop FSM that finishes frames cleanly.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int HBP = DEF_HBP,
  parameter int HAC = DEF_HAC,
  parameter int HFP = DEF_HFP,
  parameter int VBP = DEF_VBP,
  parameter int VAC = DEF_VAC,
  parameter int VFP = DEF_VFP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic             o_vs,
  output logic             o_hs,
  output logic             o_de,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_frame_done,
  output logic             o_busy
);

  localparam int HTOT = vt_period(HBP, HAC, HFP);
  localparam int VTOT = vt_period(VBP, VAC, VFP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HTOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VTOT - 1);
  localparam logic [CNT_W-1:0] H_ACT_LO = CNT_W'(1 + HBP);
  localparam logic [CNT_W-1:0] H_ACT_HI = CNT_W'(HBP + HAC);
  localparam logic [CNT_W-1:0] V_ACT_LO = CNT_W'(1 + VBP);
  localparam logic [CNT_W-1:0] V_ACT_HI = CNT_W'(VBP + VAC);

  if (HTOT > (1 << CNT_W) || VTOT > (1 << CNT_W)) begin : g_size_check
    $error("video_timing_gen: HTOT or VTOT exceeds the 12-bit counter range");
  end
  if (HBP < 1 || HFP < 1 || VBP < 1 || VFP < 1) begin : g_porch_check
    $error("video_timing_gen: every porch parameter must be at least 1");
  end

  vt_state_e        r_state;
  vt_state_e        w_state_nxt;
  logic             w_busy;
  logic             w_busy_nxt;
  logic             w_frame_end;
  logic             w_clr;
  logic             w_h_tc;
  logic             w_v_tc;
  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_nxt;
  logic             w_h_act;
  logic             w_v_act;
  logic             w_de_nxt;

  logic             r_vs;
  logic             r_hs;
  logic             r_de;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_frame_done;
  logic             r_busy;

  assign w_busy      = (r_state == ST_RUN) || (r_state == ST_STOP);
  assign w_frame_end = w_busy & w_h_tc & w_v_tc;
  assign w_busy_nxt  = (w_state_nxt != ST_IDLE);
  assign w_clr       = ~w_busy_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A frame in flight always completes; i_en only decides what follows it.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (i_en) w_state_nxt = ST_RUN;
      end
      ST_RUN, ST_STOP: begin
        if (w_frame_end) w_state_nxt = i_en ? ST_RUN : ST_IDLE;
        else             w_state_nxt = i_en ? ST_RUN : ST_STOP;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  video_wrap_cnt #(.W(CNT_W), .LAST(H_LAST)) u_h_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (w_busy),
    .o_nxt (w_h_nxt),
    .o_tc  (w_h_tc)
  );

  video_wrap_cnt #(.W(CNT_W), .LAST(V_LAST)) u_v_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (w_busy & w_h_tc),
    .o_nxt (w_v_nxt),
    .o_tc  (w_v_tc)
  );

  assign w_h_act  = (w_h_nxt >= H_ACT_LO) && (w_h_nxt <= H_ACT_HI);
  assign w_v_act  = (w_v_nxt >= V_ACT_LO) && (w_v_nxt <= V_ACT_HI);
  assign w_de_nxt = w_busy_nxt & w_h_act & w_v_act;

  // Outputs are decoded from next-cycle counts so they line up with h/v.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs         <= 1'b0;
      r_hs         <= 1'b0;
      r_de         <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_hs         <= w_busy_nxt & (w_h_nxt == '0);
      r_vs         <= w_busy_nxt & (w_h_nxt == '0) & (w_v_nxt == '0);
      r_de         <= w_de_nxt;
      r_x          <= w_de_nxt ? (w_h_nxt - H_ACT_LO) : '0;
      r_y          <= (w_busy_nxt & w_v_act) ? (w_v_nxt - V_ACT_LO) : '0;
      r_frame_done <= w_busy_nxt & (w_h_nxt == H_LAST) & (w_v_nxt == V_LAST);
    end
  end

  assign o_vs         = r_vs;
  assign o_hs         = r_hs;
  assign o_de         = r_de;
  assign o_x          = r_x;
  assign o_y          = r_y;
  assign o_frame_done = r_frame_done;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small-config DUT checked cycle by cycle against
// a reference model scoreboard, plus a default-parameter DUT checked over lines.
module tb_video_timing_gen;

  localparam int HBP = 2, HAC = 4, HFP = 2, VBP = 1, VAC = 3, VFP = 1;
  localparam int HTOT = 9, VTOT = 6;
  localparam int D_HTOT = 1927;

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        fd;
    logic        busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_en = 1'b0;
  logic        i_en_d = 1'b0;
  logic        vs, hs, de, fd, busy;
  logic [11:0] x, y;
  logic        d_vs, d_hs, d_de, d_fd, d_busy;
  logic [11:0] d_x, d_y;

  int checks = 0;
  int errors = 0;

  exp_t q[$];
  int   m_st, mh, mv;
  int   cyc;
  int   vs_at[$];
  int   fd_at[$];
  int   xq[$];
  int   yq[$];
  int   hs_n, de_n, late_hs, last_busy;

  always #5 clk = ~clk;

  video_timing_gen #(.HBP(HBP), .HAC(HAC), .HFP(HFP), .VBP(VBP), .VAC(VAC), .VFP(VFP)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .o_vs(vs), .o_hs(hs), .o_de(de),
    .o_x(x), .o_y(y), .o_frame_done(fd), .o_busy(busy)
  );

  video_timing_gen dut_def (
    .clk(clk), .rst(rst), .i_en(i_en_d), .o_vs(d_vs), .o_hs(d_hs), .o_de(d_de),
    .o_x(d_x), .o_y(d_y), .o_frame_done(d_fd), .o_busy(d_busy)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference model: advance one cycle under the given i_en and push the
  // outputs expected during the following cycle.
  task automatic model_step(input logic en);
    exp_t e;
    logic b;
    logic last;
    if (m_st == 0) begin
      if (en) m_st = 1;
    end else begin
      last = (mh == HTOT-1) && (mv == VTOT-1);
      if (mh == HTOT-1) begin
        mh = 0;
        mv = (mv == VTOT-1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      if (last) begin
        if (en) m_st = 1;
        else begin m_st = 0; mh = 0; mv = 0; end
      end else begin
        m_st = en ? 1 : 2;
      end
    end
    b      = (m_st != 0);
    e.busy = b;
    e.hs   = b && (mh == 0);
    e.vs   = b && (mh == 0) && (mv == 0);
    e.de   = b && (mh >= 1+HBP) && (mh <= HBP+HAC) && (mv >= 1+VBP) && (mv <= VBP+VAC);
    e.x    = e.de ? 12'(mh-1-HBP) : 12'd0;
    e.y    = (b && (mv >= 1+VBP) && (mv <= VBP+VAC)) ? 12'(mv-1-VBP) : 12'd0;
    e.fd   = b && (mh == HTOT-1) && (mv == VTOT-1);
    q.push_back(e);
  endtask

  task automatic clear_stats();
    vs_at.delete(); fd_at.delete(); xq.delete(); yq.delete();
    hs_n = 0; de_n = 0; late_hs = 0; last_busy = 0;
  endtask

  task automatic cycle(input logic en);
    exp_t e, a;
    i_en = en;
    model_step(en);
    @(posedge clk); #1;
    cyc++;
    e = q.pop_front();
    a = '{vs: vs, hs: hs, de: de, x: x, y: y, fd: fd, busy: busy};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL scoreboard cyc=%0d got vs=%b hs=%b de=%b x=%0d y=%0d fd=%b busy=%b exp vs=%b hs=%b de=%b x=%0d y=%0d fd=%b busy=%b",
               cyc, a.vs, a.hs, a.de, a.x, a.y, a.fd, a.busy, e.vs, e.hs, e.de, e.x, e.y, e.fd, e.busy);
    end else begin
      $display("txn cyc=%0d en=%b vs=%b hs=%b de=%b x=%0d y=%0d fd=%b busy=%b", cyc, en, vs, hs, de, x, y, fd, busy);
    end
    if (vs) vs_at.push_back(cyc);
    if (hs) hs_n++;
    if (hs && cyc > 54) late_hs++;
    if (de) begin de_n++; xq.push_back(int'(x)); yq.push_back(int'(y)); end
    if (fd) fd_at.push_back(cyc);
    if (busy) last_busy = cyc;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); m_st = 0; mh = 0; mv = 0; cyc = 0;
    clear_stats();
  endtask

  task automatic check_s1_timing(input string tag);
    int exp_vs[3] = '{1, 55, 109};
    int exp_fd[2] = '{54, 108};
    checks++;
    if (vs_at.size() != 3) begin
      errors++; $display("FAIL %s_vs_count got %0d exp 3", tag, vs_at.size());
    end else foreach (exp_vs[i]) begin
      checks++;
      if (vs_at[i] != exp_vs[i]) begin errors++; $display("FAIL %s_vs_cycle got %0d exp %0d", tag, vs_at[i], exp_vs[i]); end
    end
    checks++;
    if (hs_n != 14) begin errors++; $display("FAIL %s_hs_count got %0d exp 14", tag, hs_n); end
    checks++;
    if (de_n != 24) begin errors++; $display("FAIL %s_de_count got %0d exp 24", tag, de_n); end
    checks++;
    if (fd_at.size() != 2) begin
      errors++; $display("FAIL %s_fd_count got %0d exp 2", tag, fd_at.size());
    end else foreach (exp_fd[i]) begin
      checks++;
      if (fd_at[i] != exp_fd[i]) begin errors++; $display("FAIL %s_fd_cycle got %0d exp %0d", tag, fd_at[i], exp_fd[i]); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({vs, hs, de, x, y, fd, busy} !== 29'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {vs, hs, de, x, y, fd, busy});
    end
    do_reset();
    repeat (5) cycle(1'b0);
  endtask

  task automatic test_scenario1();
    do_reset();
    repeat (118) cycle(1'b1);
    check_s1_timing("s1");
  endtask

  task automatic test_xy();
    do_reset();
    repeat (55) cycle(1'b1);
    checks++;
    if (xq.size() != 12) begin
      errors++; $display("FAIL xy_count got %0d exp 12", xq.size());
    end else for (int i = 0; i < 12; i++) begin
      checks++;
      if (xq[i] != i % 4 || yq[i] != i / 4) begin
        errors++; $display("FAIL xy_seq idx=%0d got x=%0d y=%0d exp x=%0d y=%0d", i, xq[i], yq[i], i % 4, i / 4);
      end
    end
  endtask

  task automatic test_stop();
    do_reset();
    repeat (20) cycle(1'b1);
    while (cyc < 80) cycle(1'b0);
    checks++;
    if (fd_at.size() != 1 || (fd_at.size() == 1 && fd_at[0] != 54)) begin
      errors++; $display("FAIL stop_fd got count=%0d first=%0d exp count=1 at 54", fd_at.size(), (fd_at.size() > 0) ? fd_at[0] : -1);
    end
    checks++;
    if (last_busy != 54) begin errors++; $display("FAIL stop_busy_end got %0d exp 54", last_busy); end
    checks++;
    if (late_hs != 0) begin errors++; $display("FAIL stop_late_hs got %0d exp 0", late_hs); end
  endtask

  task automatic test_back_to_back_glitch();
    do_reset();
    for (int c = 0; c < 118; c++) begin
      cycle(!((c >= 10 && c < 25) || (c >= 40 && c < 54)));
    end
    check_s1_timing("s4");
  endtask

  task automatic test_rst_mid();
    int n;
    do_reset();
    n = 0;
    while (!(m_st != 0 && mh == 5 && mv == 3) && n < 100) begin
      cycle(1'b1);
      n++;
    end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL rst_mid_reach got n=%0d exp < 100", n); end
    #2;
    rst = 1'b1;
    i_en = 1'b0;
    #1;
    checks++;
    if ({vs, hs, de, x, y, fd, busy} !== 29'd0) begin
      errors++; $display("FAIL rst_mid_async got %h exp 0", {vs, hs, de, x, y, fd, busy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); m_st = 0; mh = 0; mv = 0; cyc = 0;
    clear_stats();
    repeat (3) cycle(1'b0);
    cycle(1'b1);
    checks++;
    if (vs !== 1'b1 || hs !== 1'b1) begin
      errors++; $display("FAIL rst_restart_vs got vs=%b hs=%b exp 1 1", vs, hs);
    end
    repeat (10) cycle(1'b1);
  endtask

  task automatic test_default();
    int hs_cnt, vs_cnt, de_cnt, fd_cnt, hs_bad, not_busy, max_x, first_y, last_y;
    logic seen;
    hs_cnt = 0; vs_cnt = 0; de_cnt = 0; fd_cnt = 0; hs_bad = 0; not_busy = 0;
    max_x = 0; first_y = -1; last_y = -1; seen = 1'b0;
    i_en_d = 1'b1;
    for (int k = 1; k <= 6 * D_HTOT; k++) begin
      @(posedge clk); #1;
      if (d_hs) begin hs_cnt++; if ((k - 1) % D_HTOT != 0) hs_bad++; end
      if (d_vs) vs_cnt++;
      if (d_fd) fd_cnt++;
      if (!d_busy) not_busy++;
      if (d_de) begin
        de_cnt++;
        if (int'(d_x) > max_x) max_x = int'(d_x);
        if (!seen) begin first_y = int'(d_y); seen = 1'b1; end
        last_y = int'(d_y);
      end
    end
    i_en_d = 1'b0;
    $display("txn default lines=6 hs=%0d vs=%0d de=%0d max_x=%0d", hs_cnt, vs_cnt, de_cnt, max_x);
    checks++;
    if (hs_cnt != 6 || hs_bad != 0) begin errors++; $display("FAIL def_hs got count=%0d misplaced=%0d exp 6 0", hs_cnt, hs_bad); end
    checks++;
    if (vs_cnt != 1) begin errors++; $display("FAIL def_vs got %0d exp 1", vs_cnt); end
    checks++;
    if (de_cnt != 2 * 1920) begin errors++; $display("FAIL def_de got %0d exp 3840", de_cnt); end
    checks++;
    if (max_x != 1919) begin errors++; $display("FAIL def_max_x got %0d exp 1919", max_x); end
    checks++;
    if (first_y != 0 || last_y != 1) begin errors++; $display("FAIL def_y got first=%0d last=%0d exp 0 1", first_y, last_y); end
    checks++;
    if (fd_cnt != 0 || not_busy != 0) begin errors++; $display("FAIL def_busy got fd=%0d idle_cycles=%0d exp 0 0", fd_cnt, not_busy); end
  endtask

  initial begin
    test_reset();
    test_scenario1();
    test_xy();
    test_stop();
    test_back_to_back_glitch();
    test_rst_mid();
    test_default();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
